// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter state encoding, parity modes and frame helpers
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  function automatic logic [3:0] data_bits(input logic [1:0] len);
    return 4'd5 + {2'b00, len};
  endfunction

  function automatic logic parity_on(input logic [1:0] par);
    return (par == PAR_ODD) || (par == PAR_EVEN);
  endfunction

  // Parity covers only the bits that go on the line; odd mode inverts the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] len,
                                      input logic [1:0] par);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - len);
    return (^(data & mask)) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - byte FIFO with push/pop/flush and occupancy level
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [7:0]                push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [7:0]                pop_data,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok  = push && !flush && (level_q != LW'(DEPTH));
  assign pop_ok   = pop && (level_q != '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  // A flush wins over everything; a pop on the same edge still hands out the head byte.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter: FIFO, frame FSM, bit divisor and shifter
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_len,
  input  logic [1:0]                    cfg_par,
  input  logic                          cfg_stop2,
  input  logic                          tx_en,
  input  logic                          flush,
  input  logic [$clog2(FIFO_DEPTH):0]   cfg_thresh,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          irq_lvl,
  output logic                          irq_done
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]     nbits_q, nbits_d;
  logic           par_en_q, par_en_d;
  logic           par_val_q, par_val_d;
  logic           stop2_q, stop2_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           irq_lvl_q, irq_lvl_d;
  logic           irq_done_q, irq_done_d;
  logic           run_q, run_d;

  logic           fifo_pop;
  logic [7:0]     fifo_data;
  logic [LW-1:0]  fifo_level;
  logic           bit_end;
  logic           can_start;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .flush     (flush),
    .pop_data  (fifo_data),
    .level     (fifo_level)
  );

  // run_q keeps in_ready low through reset and for the release edge itself.
  assign in_ready  = run_q && (fifo_level < LW'(FIFO_DEPTH)) && !flush;
  assign bit_end   = (div_cnt_q == div_lat_q - DIV_W'(1));
  assign can_start = tx_en && (fifo_level != '0);

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign level    = fifo_level;
  assign irq_lvl  = irq_lvl_q;
  assign irq_done = irq_done_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    div_lat_d  = div_lat_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_val_d  = par_val_q;
    stop2_d    = stop2_q;
    sh_d       = sh_q;
    irq_done_d = 1'b0;
    run_d      = 1'b1;
    fifo_pop   = 1'b0;

    if (state_q != ST_IDLE) div_cnt_d = bit_end ? '0 : div_cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (can_start) fifo_pop = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if ({1'b0, bit_cnt_q} == nbits_q - 4'd1) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == 3'd0)) begin
            bit_cnt_d = 3'd1;
          end else if (can_start) begin
            fifo_pop = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            irq_done_d = (fifo_level == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame configuration is captured together with the byte it applies to.
    if (fifo_pop) begin
      state_d   = ST_START;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      div_lat_d = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
      nbits_d   = data_bits(cfg_len);
      par_en_d  = parity_on(cfg_par);
      par_val_d = parity_bit(fifo_data, cfg_len, cfg_par);
      stop2_d   = cfg_stop2;
      sh_d      = fifo_data;
    end

    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sh_q[0];
      ST_PARITY: tx_d = par_val_q;
      default:   tx_d = 1'b1;
    endcase

    busy_d    = (state_d != ST_IDLE);
    irq_lvl_d = tx_en && (fifo_level <= cfg_thresh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      div_lat_q  <= DIV_W'(2);
      bit_cnt_q  <= '0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_val_q  <= 1'b0;
      stop2_q    <= 1'b0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      irq_lvl_q  <= 1'b0;
      irq_done_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_val_q  <= par_val_d;
      stop2_q    <= stop2_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      irq_lvl_q  <= irq_lvl_d;
      irq_done_q <= irq_done_d;
      run_q      <= run_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - scoreboard bench: expected frames queued at push, serial monitor decodes tx
module tb_uart_tx_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_len = 2'b11;
  logic [1:0]  cfg_par = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        tx_en = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  cfg_thresh = 5'd4;
  logic        tx;
  logic        busy;
  logic [4:0]  level;
  logic        irq_lvl;
  logic        irq_done;

  uart_tx_buf #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_div(cfg_div), .cfg_len(cfg_len), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2),
    .tx_en(tx_en), .flush(flush), .cfg_thresh(cfg_thresh), .tx(tx), .busy(busy),
    .level(level), .irq_lvl(irq_lvl), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          div;
    bit          b2b;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int irq_cnt = 0;
  bit mon_active = 0;
  bit stray = 0;

  // par: 0 none, 1 odd, 2 even. Bit 0 of the vector is the start bit.
  function automatic frame_t mk(input logic [7:0] d, input int nb, input int par,
                                input int stops, input int div, input bit b2b);
    frame_t f;
    int ones = 0;
    int k;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int j = 0; j < nb; j++) begin
      f.bits[1+j] = d[j];
      if (d[j]) ones++;
    end
    k = 1 + nb;
    if (par != 0) begin
      f.bits[k] = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      k++;
    end
    f.n   = k + stops;
    f.div = div;
    f.b2b = b2b;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Serial monitor: every sample of every bit must match the frame at the queue head.
  initial begin
    frame_t cur;
    int idx = 0;
    int cnt = 0;
    int bad_idx = -1;
    int last_end = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (irq_done === 1'b1) irq_cnt++;
      if (!rst_n) begin
        mon_active = 0;
        stray = 0;
      end else begin
        if (stray && tx === 1'b1) stray = 0;
        if (!mon_active && !stray && tx === 1'b0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            stray = 1;
            $display("FAIL unexpected_frame actual=start_bit expected=idle cycle=%0d", cyc);
          end else begin
            cur = sb.pop_front();
            mon_active = 1;
            idx = 0;
            cnt = 0;
            bad_idx = -1;
            if (cur.b2b) begin
              checks++;
              if (cyc != last_end) begin
                errors++;
                $display("FAIL b2b_gap actual_start=%0d expected_start=%0d", cyc, last_end);
              end
            end
          end
        end
        if (mon_active) begin
          if (tx !== cur.bits[idx] && bad_idx < 0) bad_idx = idx * 1000 + cnt;
          cnt++;
          if (cnt == cur.div) begin
            cnt = 0;
            idx++;
            if (idx == cur.n) begin
              checks++;
              if (bad_idx >= 0) begin
                errors++;
                $display("FAIL frame_bits first_bad(bit*1000+clk)=%0d expected_bits=%b n=%0d div=%0d",
                         bad_idx, cur.bits, cur.n, cur.div);
              end
              mon_active = 0;
              last_end = cyc + 1;
              frames_done++;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_active && !stray && busy === 1'b0) break;
    end
    checks++;
    if (i == 4000) begin
      errors++;
      $display("FAIL %s_timeout actual=busy expected=idle within 4000 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  // Single push into an empty, idle transmitter: tx must fall exactly two edges after accept.
  task automatic push_one(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("tx_after_accept", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("tx_after_pop", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("tx_start_2_edges", {31'd0, tx}, 32'd0);
  endtask

  task automatic push_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = first + 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int irq0;
    int fd0;
    // Reset state
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_irq_lvl", {31'd0, irq_lvl}, 32'd0);
    chk("rst_irq_done", {31'd0, irq_done}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // 8N1 div 4, 0x55
    tx_en = 1'b1;
    irq0 = irq_cnt;
    sb.push_back(mk(8'h55, 8, 0, 1, 4, 0));
    push_one(8'h55);
    wait_idle("8n1_55");
    chk("8n1_irq_done", irq_cnt - irq0, 32'd1);
    chk("8n1_busy", {31'd0, busy}, 32'd0);
    chk("8n1_irq_lvl", {31'd0, irq_lvl}, 32'd1);

    // Parity and length variants, plus divisor clamping
    cfg_div = 16'd3; cfg_par = 2'b10;
    sb.push_back(mk(8'h07, 8, 2, 1, 3, 0));
    push_one(8'h07);
    wait_idle("8e1_07");
    cfg_par = 2'b01;
    sb.push_back(mk(8'h07, 8, 1, 1, 3, 0));
    push_one(8'h07);
    wait_idle("8o1_07");
    cfg_par = 2'b00; cfg_len = 2'b10; cfg_stop2 = 1'b1;
    sb.push_back(mk(8'h80, 7, 0, 2, 3, 0));
    push_one(8'h80);
    wait_idle("7n2_80");
    cfg_div = 16'd0; cfg_len = 2'b00; cfg_stop2 = 1'b0;
    sb.push_back(mk(8'h1F, 5, 0, 1, 2, 0));
    push_one(8'h1F);
    wait_idle("5n1_div0");
    cfg_div = 16'd1; cfg_len = 2'b01; cfg_par = 2'b11;
    sb.push_back(mk(8'h2A, 6, 0, 1, 2, 0));
    push_one(8'h2A);
    wait_idle("6n1_div1");

    // Fill: 18 consecutive offers, 17 accepted, frames back to back
    cfg_div = 16'd8; cfg_len = 2'b11; cfg_par = 2'b00;
    for (int k = 0; k < 17; k++) sb.push_back(mk(8'hA0 + 8'(k), 8, 0, 1, 8, k != 0));
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      chk($sformatf("fill_ready_%0d", k), {31'd0, in_ready}, (k < 17) ? 32'd1 : 32'd0);
      if (k == 17) begin
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_irq_lvl", {31'd0, irq_lvl}, 32'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("fill");
    chk("fill_level_end", {27'd0, level}, 32'd0);

    // Flush during frame 2 of 5
    cfg_div = 16'd4;
    irq0 = irq_cnt;
    sb.push_back(mk(8'h10, 8, 0, 1, 4, 0));
    sb.push_back(mk(8'h11, 8, 0, 1, 4, 1));
    fd0 = frames_done;
    push_burst(8'h10, 5);
    for (int i = 0; i < 200 && frames_done == fd0; i++) @(negedge clk);
    chk("flush_frame1_done", frames_done - fd0, 32'd1);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_level", {27'd0, level}, 32'd0);
    wait_idle("flush");
    repeat (60) @(negedge clk);
    chk("flush_irq_done", irq_cnt - irq0, 32'd1);
    chk("flush_frames", frames_done - fd0, 32'd2);

    // tx_en falling mid-frame: current frame completes, next waits
    sb.push_back(mk(8'h42, 8, 0, 1, 4, 0));
    push_burst(8'h42, 2);
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    wait_idle("txen_off");
    repeat (30) @(negedge clk);
    chk("txen_off_level", {27'd0, level}, 32'd1);
    chk("txen_off_busy", {31'd0, busy}, 32'd0);
    chk("txen_off_irq_lvl", {31'd0, irq_lvl}, 32'd0);
    sb.push_back(mk(8'h43, 8, 0, 1, 4, 0));
    tx_en = 1'b1;
    wait_idle("txen_on");
    chk("txen_on_level", {27'd0, level}, 32'd0);

    // Reset in the middle of the data bits
    sb.push_back(mk(8'h00, 8, 0, 1, 4, 0));
    push_one(8'h00);
    repeat (5) @(negedge clk);
    chk("mid_data_tx", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_level", {27'd0, level}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_sb_empty", sb.size(), 32'd0);
    sb.push_back(mk(8'h3C, 8, 0, 1, 4, 0));
    push_one(8'h3C);
    wait_idle("after_reset");

    // Divisor change mid-frame applies from the next frame
    sb.push_back(mk(8'hC3, 8, 0, 1, 4, 0));
    sb.push_back(mk(8'hC4, 8, 0, 1, 6, 1));
    push_burst(8'hC3, 2);
    repeat (10) @(negedge clk);
    cfg_div = 16'd6;
    wait_idle("div_change");
    chk("div_change_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
